// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues sequential SRAM reads and queues the
// returned words with their PCs in a small FIFO for the CPU front end.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   redirect          flush and restart fetch at redirect_pc
//   redirect_pc       new fetch target (bits [1:0] ignored)
//   instr_ready       CPU accepts the FIFO head this cycle
//   instr_valid       FIFO head valid
//   instr_out         instruction word at FIFO head
//   instr_pc          byte address of instr_out
//   im_ceb            SRAM chip enable, active low (low = issue)
//   im_a              SRAM word address, fetch_pc[15:2]
//   im_do             SRAM read data, valid the cycle after an issue
module ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        im_ceb,
  output logic [13:0] im_a,
  input  logic [31:0] im_do
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_infl_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];

  logic [CW-1:0] w_occ;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;

  // Counting the in-flight read as occupied reserves its FIFO slot,
  // so a returning word can never find the FIFO full.
  assign w_occ   = r_count + CW'(r_inflight);
  assign w_issue = ~rst & ~redirect & (w_occ < CW'(DEPTH));
  // A redirect kills the word arriving this cycle.
  assign w_push  = r_inflight & ~redirect;
  assign w_pop   = instr_valid & instr_ready & ~redirect;

  assign instr_valid = (r_count != '0);
  assign instr_out   = instr_valid ? r_instr[r_rd_ptr] : '0;
  assign instr_pc    = instr_valid ? r_pc[r_rd_ptr] : '0;
  assign im_ceb      = ~w_issue;
  assign im_a        = r_fetch_pc[15:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_infl_pc  <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_infl_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by instr_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= im_do;
      r_pc[r_wr_ptr]    <= r_infl_pc;
    end
  end

endmodule
